// File: rtl/mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter
//
// Round-robin arbiter and sequencer for a shared 2:1 multiplexer channel.
// Two requesters compete for one output path. One requester is granted at a
// time. The block drives the mux select and enable, and registers the selected
// data onto the shared output.
//
// Each grant has a bounded hold time while the other side is waiting. On every
// owner change a one-cycle dead gap is inserted, so the mux never switches
// while it is enabled.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req0/req1  requests; each is held high for the whole transfer
//   in0_data   requester 0 data
//   in1_data   requester 1 data
//   gnt0/gnt1  registered grants; never both high
//   sel        registered mux select (0 = in0_data, 1 = in1_data)
//   enb        mux enable, equal to gnt0 | gnt1
//   out_data   registered mux output; holds its value while enb is low
//   out_valid  out_data carries a granted requester's data
//   busy       FSM is not idle
//
// States
//   IDLE   | no owner; waiting for a request
//   GNT0   | requester 0 owns the channel
//   GNT1   | requester 1 owns the channel
//   SWITCH | one-cycle dead gap between owners; enable is low, select held
// -----------------------------------------------------------------------------
module mux2_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in0_data,
    input  logic [WIDTH-1:0] in1_data,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             enb,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT0   = 2'd1,
        GNT1   = 2'd2,
        SWITCH = 2'd3
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               sel_q, sel_d;
    logic               gnt0_q, gnt1_q;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    logic               grant_take;
    logic               grant_id;
    logic               req_other;
    logic               req_last;
    logic               own_req;
    logic               oth_req;
    logic               enb_w;

    assign enb_w = gnt0_q | gnt1_q;

    // Next-state decision. Any path that hands the channel to a requester
    // goes through grant_take, so entry actions are applied in one place:
    // the counter is cleared, the owner is remembered, and the select is set.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        grant_take = 1'b0;
        grant_id   = 1'b0;

        // "other" is the side that did not own the channel most recently.
        req_other  = last_q ? req0 : req1;
        req_last   = last_q ? req1 : req0;
        own_req    = (state_q == GNT1) ? req1 : req0;
        oth_req    = (state_q == GNT1) ? req0 : req1;

        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    grant_take = 1'b1;
                    grant_id   = ~last_q;
                end else if (req0) begin
                    grant_take = 1'b1;
                    grant_id   = 1'b0;
                end else if (req1) begin
                    grant_take = 1'b1;
                    grant_id   = 1'b1;
                end
            end

            GNT0, GNT1: begin
                // A release takes priority over preemption; both outcomes
                // lead to SWITCH when the other side is waiting.
                if (!own_req) begin
                    state_d    = oth_req ? SWITCH : IDLE;
                    hold_cnt_d = '0;
                end else if (oth_req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d    = SWITCH;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end

            SWITCH: begin
                // Requests are re-sampled here. If a preempting requester
                // has vanished, the previous owner can get the channel back.
                if (req_other) begin
                    grant_take = 1'b1;
                    grant_id   = ~last_q;
                end else if (req_last) begin
                    grant_take = 1'b1;
                    grant_id   = last_q;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase

        if (grant_take) begin
            state_d    = grant_id ? GNT1 : GNT0;
            hold_cnt_d = '0;
            last_d     = grant_id;
            sel_d      = grant_id;
        end
    end

    // The datapath uses the currently registered enable and select. Data
    // therefore follows the grant by one edge.
    always_comb begin
        out_data_d  = enb_w ? (sel_q ? in1_data : in0_data) : out_data_q;
        out_valid_d = enb_w & (sel_q ? req1 : req0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            hold_cnt_q  <= '0;
            sel_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            sel_q       <= sel_d;
            gnt0_q      <= (state_d == GNT0);
            gnt1_q      <= (state_d == GNT1);
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sel       = sel_q;
    assign enb       = enb_w;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter and sequencer for the shared 2x1 multiplexer channel. Two requesters compete for one output path. The block grants one requester at a time, drives the mux select and enable, and registers the selected data onto the shared output. It enforces a maximum hold time per grant and inserts a one-cycle dead gap on every owner change, so the mux never switches while enabled.

## Interface
- WIDTH, 8, data width of each requester input and of out_data
- MAX_HOLD, 4, maximum consecutive granted cycles while the other side is waiting (legal range 2..255)
- HOLD_W, 8, width of the hold counter (must satisfy 2^HOLD_W > MAX_HOLD)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 wants the channel; held high for the whole transfer
- req1  in  1  requester 1 wants the channel
- in0_data  in  WIDTH  requester 0 data
- in1_data  in  WIDTH  requester 1 data
- gnt0  out  1  requester 0 owns the channel (registered)
- gnt1  out  1  requester 1 owns the channel (registered)
- sel  out  1  mux select: 0 = in0_data, 1 = in1_data (registered)
- enb  out  1  mux enable; equals gnt0 | gnt1
- out_data  out  WIDTH  registered mux output
- out_valid  out  1  out_data holds a granted requester's data
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, GNT0, GNT1, SWITCH. `last` is a 1-bit pointer to the most recent owner; it is reset to 1, so requester 0 wins the first tie.
- IDLE:
  - req0 & req1 -> GNT(~last).
  - Only reqX -> GNTX.
  - No request -> stay in IDLE.
- GNTX:
  - On entry, gntX=1, sel=X, enb=1, hold_cnt=0, last=X.
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - reqX=0 and other req=1 -> SWITCH.
  - reqX=0 and other req=0 -> IDLE.
  - reqX=1, other req=1 and hold_cnt==MAX_HOLD-1 -> SWITCH (preemption).
  - Otherwise stay in GNTX.
- SWITCH:
  - gnt0=gnt1=0 and enb=0; sel holds its value.
  - Lasts exactly one cycle. Next state: the other side (~last) if it still requests, else `last` if it still requests, else IDLE.
- Datapath:
  - Every cycle, out_data <= enb ? (sel ? in1_data : in0_data) : out_data.
  - out_valid <= enb & (sel ? req1 : req0).
  - out_data holds its value when not enabled.
- gnt0 and gnt1 are never both 1. sel changes only while enb=0, or on the same edge that enb rises.
- A grant is never issued to a requester whose req is low on the deciding edge.

## Timing
- Reset values: gnt0=0, gnt1=0, sel=0, enb=0, out_data=0, out_valid=0, busy=0, state=IDLE, hold_cnt=0, last=1.
- rst_n low forces the reset values immediately, regardless of clk, including mid-grant. Release is synchronous to the next rising edge; the first decision is made on the first edge with rst_n high.
- Request to grant: reqX sampled high at edge k in IDLE -> gntX high after edge k (1-cycle latency).
- Grant to data: out_data/out_valid reflect the granted input one edge after gnt rises.
- Release: reqX low at edge k -> gntX low after edge k.
- Owner change: SWITCH occupies exactly one cycle with enb=0; the new owner's gnt rises after the following edge.
- Preemption: with both sides requesting continuously, each owner holds gnt for exactly MAX_HOLD cycles, followed by 1 dead cycle. Period = 2*(MAX_HOLD+1) cycles.
- Simultaneous events:
  - Release and preemption in the same cycle -> release rules apply (both go to SWITCH).
  - A request arriving during SWITCH is honoured on the SWITCH exit edge.

## Test plan
- Reset: assert rst_n=0 mid-GNT1 with req1=1 -> gnt1, enb and out_valid drop to 0 without a clock edge; after release with req0=req1=1, the first grant goes to requester 0.
- Single requester: req0=1 for 10 cycles, in0_data=8'hA5, req1=0 -> gnt0 rises 1 cycle after req0 and stays high all 10 cycles (no preemption), out_data=8'hA5 with out_valid=1 from the next cycle; req0 drop -> gnt0=0, then IDLE.
- Contention, MAX_HOLD=4: req0=req1=1 held for 20 cycles -> gnt0 4 cycles, 1 gap, gnt1 4 cycles, 1 gap, repeating; gnt0&gnt1 never 1; sel stable whenever enb=1.
- Early release: GNT0 active, req0 drops after 2 cycles while req1=1 -> one SWITCH cycle with enb=0, then gnt1=1 and sel=1; out_data switches to in1_data one cycle later.
- Vanishing requester: GNT0 preempted toward requester 1, but req1 drops during SWITCH while req0 is still 1 -> returns to GNT0 with hold_cnt=0; no grant ever goes to requester 1.
- Idle tie after history: last=0, both requests rise on the same edge in IDLE -> gnt1 first.
